// File: rtl/serial_pkg.sv
// ==== serial_pkg: shared types and register map for the serial receiver ====
// Rev 1.0
`default_nettype none

package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [31:0] SERIAL_RX_DATA   = 32'h0000_0000;
  localparam logic [31:0] SERIAL_RX_STATUS = 32'h0000_0004;

  localparam int ST_VALID = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_FERR  = 2;
  localparam int ST_OVR   = 3;

endpackage

`default_nettype wire

// File: rtl/serial_rx_if.sv
// ==== serial_rx_if: data-memory bus slice seen by the serial receiver ====
// Rev 1.0
`default_nettype none

interface serial_rx_if;
  logic        sel;
  logic        re;
  logic [31:0] addr;
  logic [31:0] dout;

  modport master (output sel, output re, output addr, input dout);
  modport slave  (input sel, input re, input addr, output dout);
endinterface

`default_nettype wire

// File: rtl/rx_fifo.sv
// ==== rx_fifo: first-word-fall-through byte FIFO for received characters ====
// Rev 1.0
`default_nettype none

module rx_fifo #(
  parameter int DEPTH = 8
) (
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       push,
  input  wire logic       pop,
  input  wire logic [7:0] din,
  output logic      [7:0] head,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_rx.sv
// ==== serial_rx: UART 8N1 receiver with receive FIFO and DATA/STATUS registers ====
// Rev 1.0
`default_nettype none

module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  wire logic   clock,
  input  wire logic   reset,
  input  wire logic   rx,
  serial_rx_if.slave  bus
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitidx, bitidx_n;
  logic [7:0]    shreg, shreg_n;
  logic          overrun, overrun_n;
  logic          frame_err, frame_err_n;
  logic          rx_meta, rx_sync, rx_prev;
  logic          push, ovr_set, ferr_set;
  logic          pop_req, clr_req, pop_ok;
  logic [7:0]    head;
  logic          empty, full;
  logic          unused_addr;

  assign unused_addr = ^{bus.addr[31:3], bus.addr[1:0]};
  assign pop_req     = bus.sel & bus.re & (bus.addr[2] == SERIAL_RX_DATA[2]);
  assign clr_req     = bus.sel & bus.re & (bus.addr[2] == SERIAL_RX_STATUS[2]);
  assign pop_ok      = pop_req & ~empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      state     <= state_n;
      cnt       <= cnt_n;
      bitidx    <= bitidx_n;
      shreg     <= shreg_n;
      overrun   <= overrun_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitidx_n = bitidx;
    shreg_n  = shreg;
    push     = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev & ~rx_sync) begin
          state_n = START;
          cnt_n   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_sync) begin
            state_n  = DATA;
            cnt_n    = FULL_LOAD;
            bitidx_n = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_n  = {rx_sync, shreg[7:1]};
          cnt_n    = FULL_LOAD;
          bitidx_n = bitidx + 3'd1;
          if (bitidx == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          state_n = IDLE;
          if (rx_sync) begin
            if (!full || pop_ok) begin
              push = 1'b1;
            end else begin
              ovr_set = 1'b1;
            end
          end else begin
            ferr_set = 1'b1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // A flag raised in the same cycle as a STATUS read survives the clear.
    overrun_n   = ovr_set  | (overrun   & ~clr_req);
    frame_err_n = ferr_set | (frame_err & ~clr_req);
  end

  rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop_req),
    .din   (shreg),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    bus.dout = '0;
    if (bus.addr[2] == SERIAL_RX_STATUS[2]) begin
      bus.dout[ST_VALID] = ~empty;
      bus.dout[ST_FULL]  = full;
      bus.dout[ST_FERR]  = frame_err;
      bus.dout[ST_OVR]   = overrun;
    end else begin
      bus.dout[8]   = ~empty;
      bus.dout[7:0] = head;
    end
  end

endmodule

`default_nettype wire

// File: doc/serial_rx.md
# serial_rx

UART 8N1 receiver with an 8-entry receive FIFO, memory-mapped on the data-memory bus next to the existing serial transmitter. It samples the asynchronous `rx` pin on the CPU clock and frames bytes. It queues received bytes and lets software pop them or poll status through two word registers. It is the input direction of the board's serial console; the PS/2 keyboard stays a separate device.

## Interface
- `CLKS_PER_BIT`, default 434, clock cycles per bit (50 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, default 8, receive FIFO entries; power of two, ≥ 2.
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  asynchronous serial line, idle high.
- `sel`  in  1  MMU select for this device's address window.
- `re`  in  1  data-memory read enable.
- `addr`  in  32  byte address; only `addr[2]` is decoded.
- `dout`  out  32  read data, combinational from `addr` and state.

## Operation
- Input path: a 2-flop synchronizer plus one previous-value flop. All three reset to 1.
- FSM states:
  - IDLE: on a synchronized high→low edge, load `cnt = CLKS_PER_BIT/2 - 1` and go to START.
  - START: when `cnt` reaches 0, sample the line. If low, go to DATA with `cnt = CLKS_PER_BIT-1` and `bitidx = 0`. If high, treat it as a glitch and return to IDLE with no flag.
  - DATA: when `cnt` reaches 0, shift the sample in LSB-first and reload `cnt`. After `bitidx = 7` is sampled, go to STOP.
  - STOP: when `cnt` reaches 0, sample the line.
    - Sample 1, FIFO not full: push the byte.
    - Sample 1, FIFO full: drop the byte and set sticky `overrun`.
    - Sample 0: discard the byte and set sticky `frame_err`.
    - In all three cases, go to IDLE.
- IDLE requires a fresh falling edge, so a held-low break line produces one `frame_err` only.
- Register map:
  - Offset 0x0, DATA: `dout = {23'b0, ~empty, head[7:0]}`. `head` reads 0 when empty.
  - Offset 0x4, STATUS: `dout = {28'b0, overrun, frame_err, full, ~empty}`.
- Side effects, on the clock edge where `sel & re` is true:
  - At DATA (`addr[2]=0`): pop one entry if not empty. Popping an empty FIFO is a no-op.
  - At STATUS: clear `overrun` and `frame_err`. A flag set in that same cycle wins and stays set.
- FIFO behaviour:
  - Push and pop in the same cycle both take effect and the count is unchanged.
  - When full, a same-cycle pop lets the push succeed with no overrun.
  - Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. The count is one bit wider.

## Timing
- Reset values:
  - FSM IDLE, counters 0.
  - FIFO empty; `overrun` and `frame_err` 0.
  - `dout` reads 0 at both offsets.
- Reset mid-frame aborts the frame with no push and no flag. The next full frame after reset is received normally.
- Frame latency: from the `rx` falling edge to `~empty` visible is 2 (synchronizer) + 1 (edge detect) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles.
- Samples land at bit centres within ±1 cycle.
- A pop is visible on `dout` the cycle after the read edge.
- Back-to-back frames with a 1-bit stop are accepted. The next start edge is detected in the cycle after the STOP sample at the earliest.

## Structure
- Package `serial_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, STOP}.
  - Offsets `SERIAL_RX_DATA = 0`, `SERIAL_RX_STATUS = 4`.
  - Status bit indices: `ST_VALID = 0`, `ST_FULL = 1`, `ST_FERR = 2`, `ST_OVR = 3`.
- One sub-module `rx_fifo`: a synchronous FIFO with `push`, `pop`, `din[7:0]`, `head[7:0]` (first-word-fall-through), `empty`, `full`, and the same clock and reset.
- The FSM, synchronizer, flags and read mux live in `serial_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT = 16` and `FIFO_DEPTH = 8`.
- Clean frame: drive 0xA5 8N1 → DATA reads 0x1A5 after the stated latency and before any pop. After one DATA read, DATA = 0x000 and STATUS = 0x0.
- Glitch: `rx` low for 4 cycles then high → no push, STATUS stays 0x0, FSM back in IDLE.
- Framing error: 0x3C with stop bit 0 → FIFO empty, STATUS = 0x4. A second STATUS read returns 0x0.
- Overrun: send 0x00..0x08 with no reads → STATUS = 0xB. Eight DATA pops return 0x100..0x107 in order. The 9th byte is absent.
- Simultaneous events: FIFO full while a pop coincides with the STOP-sample push → count stays 8, no overrun, new byte appears last.
- Reset mid-frame: assert `reset` for 1 cycle after 4 data bits → STATUS = 0x0. The following 0x5A frame reads back 0x15A.
